// File: rtl/weight_ram_pkg.sv
// Shared definitions for the weight streaming RAM: sweep FSM states and the
// width helper used to size address and bank-select ports.
package weight_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } state_e;

   // ceil(log2(n)), never less than 1 so single-entry ranges keep a 1-bit port
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/weight_bank.sv
// One gate bank: simple dual-port RAM, one write port and one registered read
// port. Read and write of the same address in one cycle return the old word.
module weight_bank #(
   parameter int ROW_W  = 288,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [ROW_W-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [ROW_W-1:0]  rd_data_o
);

   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [ROW_W-1:0] rd_data_q;

   // write port; no reset so the array maps onto block RAM
   always_ff @(posedge clock) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   // registered read port; holds its word whenever no read is issued
   always_ff @(posedge clock) begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/weight_stream_ram.sv
// Weight store for NGATE gate banks with a column sweep engine: on start every
// column is read from all banks in parallel and streamed out with a
// valid/ready handshake, one column per cycle while the consumer keeps up.
module weight_stream_ram
   import weight_ram_pkg::*;
#(
   parameter int NROW     = 16,
   parameter int NCOL     = 16,
   parameter int BITWIDTH = 18,
   parameter int NGATE    = 4,
   localparam int ADDR_BITWIDTH = clog2_min1(NCOL),
   localparam int GSEL_BITWIDTH = clog2_min1(NGATE),
   localparam int ROW_W         = NROW * BITWIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     writeEn,
   input  logic [GSEL_BITWIDTH-1:0] gateSel,
   input  logic [ADDR_BITWIDTH-1:0] addressIn,
   input  logic [ROW_W-1:0]         rowIn,
   input  logic                     start,
   input  logic                     outReady,
   output logic [NGATE*ROW_W-1:0]   rowOut,
   output logic [ADDR_BITWIDTH-1:0] colIndex,
   output logic                     outValid,
   output logic                     busy,
   output logic                     sweepDone
);

   localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

   state_e                   state_q, state_d;
   logic [ADDR_BITWIDTH-1:0] col_q, col_d;
   logic                     done_q, done_d;
   logic                     loaded_q, loaded_d;

   logic                     rd_en;
   logic [ADDR_BITWIDTH-1:0] rd_addr;
   logic                     wr_ok;
   logic [NGATE*ROW_W-1:0]   bank_data;

   assign wr_ok = writeEn && (int'(gateSel) < NGATE) && (int'(addressIn) < NCOL);

   for (genvar g = 0; g < NGATE; g++) begin : g_bank
      weight_bank #(
         .ROW_W (ROW_W),
         .DEPTH (NCOL),
         .ADDR_W(ADDR_BITWIDTH)
      ) u_bank (
         .clock    (clock),
         .wr_en_i  (wr_ok && (gateSel == GSEL_BITWIDTH'(g))),
         .wr_addr_i(addressIn),
         .wr_data_i(rowIn),
         .rd_en_i  (rd_en && !reset),
         .rd_addr_i(rd_addr),
         .rd_data_o(bank_data[g*ROW_W +: ROW_W])
      );
   end

   // sweep sequencing: the FETCH cycle issues column 0, VALID advances on accept
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      done_d   = 1'b0;
      loaded_d = loaded_q;
      rd_en    = 1'b0;
      rd_addr  = col_q;
      case (state_q)
         IDLE: begin
            // a start landing on the sweepDone cycle is dropped
            if (start && !done_q) begin
               state_d = FETCH;
               col_d   = '0;
            end
         end
         FETCH: begin
            rd_en    = 1'b1;
            rd_addr  = col_q;
            loaded_d = 1'b1;
            state_d  = VALID;
         end
         VALID: begin
            if (outReady) begin
               if (col_q == LAST_COL) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = col_q + 1'b1;
                  col_d   = col_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, column counter and status registers; reset aborts any sweep
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         col_q    <= '0;
         done_q   <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         done_q   <= done_d;
         loaded_q <= loaded_d;
      end
   end

   // bank read registers are not reset (block RAM); mask them until the first
   // fetch after reset so rowOut reads zero, otherwise they hold the last column
   assign rowOut    = loaded_q ? bank_data : '0;
   assign colIndex  = col_q;
   assign outValid  = (state_q == VALID);
   assign busy      = (state_q != IDLE);
   assign sweepDone = done_q;

endmodule
